// File: rtl/hdlc_rx_deframer.sv
// ============================================================================
// Module   : hdlc_rx_deframer
// Purpose  : HDLC receive deframer. Hunts for flags, removes stuffed zeros and
//            assembles LSB-first octets with frame and abort status.
//            Optional FCS residue check when RX_FCS_CHECK_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hdlc_rx_deframer #(
  parameter int unsigned MIN_FRAME_BYTES = 4
) (
  input  logic       Clk_i,
  input  logic       Rst_i,
  input  logic       RxEN_i,
  input  logic       Rx_i,
  output logic [7:0] RxD_o,
  output logic       RxValid_o,
  output logic       RxSOF_o,
  output logic       RxEOF_o,
  output logic       RxFrameError_o,
  output logic       RxAbort_o,
  output logic       Rx_FlagDetect_o,
  output logic       RxFCSErr_o
);

  typedef enum logic [1:0] {
    ST_HUNT = 2'd0,
    ST_FLAG = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  ones_q, ones_d;
  // Seven registered stages; together with the live sample they span the
  // eight bits of a flag, so the flag is flushed before any of it escapes.
  logic [6:0]  dl_bit_q, dl_bit_d;
  logic [6:0]  dl_vld_q, dl_vld_d;
  logic [6:0]  asm_q, asm_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  octcnt_q, octcnt_d;
  logic        sof_pend_q, sof_pend_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        ferr_q, ferr_d;
  logic        abort_q, abort_d;
  logic        flagdet_q, flagdet_d;

  logic        is_flag, is_abort, is_stuff, is_data, take;
  logic [7:0]  byte_w;

`ifdef RX_FCS_CHECK_EN
  logic [15:0] crc_q, crc_d;
  logic        fcserr_q, fcserr_d;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction
`endif

  assign is_flag  = RxEN_i && !Rx_i && (ones_q == 3'd6);
  assign is_abort = RxEN_i &&  Rx_i && (ones_q == 3'd6);
  assign is_stuff = RxEN_i && !Rx_i && (ones_q == 3'd5);
  assign is_data  = RxEN_i && !is_flag && !is_abort && !is_stuff;
  assign take     = RxEN_i && dl_vld_q[6] && !is_flag && (state_q != ST_HUNT);
  assign byte_w   = {dl_bit_q[6], asm_q};

  always_comb begin
    state_d    = state_q;
    ones_d     = ones_q;
    dl_bit_d   = dl_bit_q;
    dl_vld_d   = dl_vld_q;
    asm_d      = asm_q;
    bitcnt_d   = bitcnt_q;
    octcnt_d   = octcnt_q;
    sof_pend_d = sof_pend_q;
    rxd_d      = rxd_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    ferr_d     = 1'b0;
    abort_d    = 1'b0;
    flagdet_d  = 1'b0;
`ifdef RX_FCS_CHECK_EN
    crc_d      = crc_q;
    fcserr_d   = 1'b0;
`endif

    if (RxEN_i) begin
      ones_d = Rx_i ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;

      if (state_q != ST_HUNT) begin
        dl_bit_d = {dl_bit_q[5:0], Rx_i};
        dl_vld_d = {dl_vld_q[5:0], is_data};
      end

      if (take) begin
        asm_d    = byte_w[7:1];
        bitcnt_d = bitcnt_q + 3'd1;
        if (state_q == ST_FLAG) begin
          state_d = ST_DATA;
        end
        if (bitcnt_q == 3'd7) begin
          valid_d    = 1'b1;
          rxd_d      = byte_w;
          sof_d      = sof_pend_q;
          sof_pend_d = 1'b0;
          octcnt_d   = (octcnt_q == 8'hFF) ? 8'hFF : octcnt_q + 8'd1;
`ifdef RX_FCS_CHECK_EN
          crc_d      = crc16_byte(crc_q, byte_w);
`endif
        end
      end

      if (is_flag) begin
        flagdet_d = 1'b1;
        if ((state_q == ST_DATA) && (octcnt_q != 8'd0)) begin
          eof_d  = 1'b1;
          ferr_d = (bitcnt_q != 3'd0) || ({24'd0, octcnt_q} < MIN_FRAME_BYTES);
`ifdef RX_FCS_CHECK_EN
          fcserr_d = (crc_q != 16'hF0B8);
`endif
        end
        state_d    = ST_FLAG;
        dl_vld_d   = '0;
        bitcnt_d   = 3'd0;
        octcnt_d   = 8'd0;
        sof_pend_d = 1'b1;
`ifdef RX_FCS_CHECK_EN
        crc_d      = 16'hFFFF;
`endif
      end

      // A completed octet on the abort sample is still delivered; only the
      // partial one behind it is dropped.
      if (is_abort) begin
        abort_d    = (state_q == ST_DATA);
        state_d    = ST_HUNT;
        dl_vld_d   = '0;
        bitcnt_d   = 3'd0;
        sof_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q    <= ST_HUNT;
      ones_q     <= 3'd0;
      dl_bit_q   <= '0;
      dl_vld_q   <= '0;
      asm_q      <= '0;
      bitcnt_q   <= 3'd0;
      octcnt_q   <= 8'd0;
      sof_pend_q <= 1'b0;
      rxd_q      <= 8'h00;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      ferr_q     <= 1'b0;
      abort_q    <= 1'b0;
      flagdet_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ones_q     <= ones_d;
      dl_bit_q   <= dl_bit_d;
      dl_vld_q   <= dl_vld_d;
      asm_q      <= asm_d;
      bitcnt_q   <= bitcnt_d;
      octcnt_q   <= octcnt_d;
      sof_pend_q <= sof_pend_d;
      rxd_q      <= rxd_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      ferr_q     <= ferr_d;
      abort_q    <= abort_d;
      flagdet_q  <= flagdet_d;
    end
  end

`ifdef RX_FCS_CHECK_EN
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      crc_q    <= 16'hFFFF;
      fcserr_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      fcserr_q <= fcserr_d;
    end
  end

  assign RxFCSErr_o = fcserr_q;
`else
  assign RxFCSErr_o = 1'b0;
`endif

  assign RxD_o           = rxd_q;
  assign RxValid_o       = valid_q;
  assign RxSOF_o         = sof_q;
  assign RxEOF_o         = eof_q;
  assign RxFrameError_o  = ferr_q;
  assign RxAbort_o       = abort_q;
  assign Rx_FlagDetect_o = flagdet_q;

endmodule

`default_nettype wire

// File: tb/tb_hdlc_rx_deframer.sv
// ============================================================================
// Module   : tb_hdlc_rx_deframer
// Purpose  : Directed self-checking bench for hdlc_rx_deframer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hdlc_rx_deframer;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxen;
  logic       rx;
  logic [7:0] rxd;
  logic       rxvalid, rxsof, rxeof, rxferr, rxabort, rxflag, rxfcserr;

  always #5 clk = ~clk;

  hdlc_rx_deframer #(.MIN_FRAME_BYTES(4)) dut (
    .Clk_i           (clk),
    .Rst_i           (rst),
    .RxEN_i          (rxen),
    .Rx_i            (rx),
    .RxD_o           (rxd),
    .RxValid_o       (rxvalid),
    .RxSOF_o         (rxsof),
    .RxEOF_o         (rxeof),
    .RxFrameError_o  (rxferr),
    .RxAbort_o       (rxabort),
    .Rx_FlagDetect_o (rxflag),
    .RxFCSErr_o      (rxfcserr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int gap = 0;
  int tx_ones = 0;

  // Event log written only by the monitor.
  logic [7:0] log_byte[$];
  logic       log_sof[$];
  int m_eof = 0, m_ferr = 0, m_abort = 0, m_flag = 0, m_fcs = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (rxvalid) begin
        log_byte.push_back(rxd);
        log_sof.push_back(rxsof);
      end
      if (rxeof) begin
        m_eof++;
        if (rxferr) m_ferr++;
        if (rxfcserr) m_fcs++;
      end
      if (rxabort) m_abort++;
      if (rxflag) m_flag++;
    end
  end

  int b_byte, b_eof, b_ferr, b_abort, b_flag, b_fcs;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_byte = log_byte.size();
    b_eof = m_eof; b_ferr = m_ferr; b_abort = m_abort; b_flag = m_flag; b_fcs = m_fcs;
  endtask

  // Called at a falling edge; returns at a falling edge.
  task automatic send_bit(input logic b);
    rx = b;
    rxen = 1'b1;
    @(negedge clk);
    if (gap > 0) begin
      rxen = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic send_raw(input logic [7:0] v, input int nb);
    for (int i = 0; i < nb; i++) send_bit(v[i]);
  endtask

  task automatic send_flag();
    send_raw(8'h7E, 8);
    tx_ones = 0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i]);
      tx_ones = v[i] ? tx_ones + 1 : 0;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end
  endtask

  task automatic settle();
    rxen = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // exp_bytes holds the octets first-in-low-byte.
  task automatic check_frame(input string t, input int nb, input logic [31:0] exp_bytes,
                             input int e_eof, input int e_ferr, input int e_abort, input int e_flag);
    logic [31:0] eb;
    eb = exp_bytes;
    check({t, ".nbytes"}, log_byte.size() - b_byte, nb);
    for (int i = 0; i < nb; i++) begin
      if (b_byte + i < log_byte.size()) begin
        check({t, ".byte"}, int'(log_byte[b_byte + i]), int'(eb[8*i +: 8]));
        check({t, ".sof"}, int'(log_sof[b_byte + i]), (i == 0) ? 1 : 0);
      end
    end
    check({t, ".eof"}, m_eof - b_eof, e_eof);
    check({t, ".ferr"}, m_ferr - b_ferr, e_ferr);
    check({t, ".abort"}, m_abort - b_abort, e_abort);
    check({t, ".flag"}, m_flag - b_flag, e_flag);
    check({t, ".fcs"}, m_fcs - b_fcs, 0);
  endtask

  initial begin
    rst = 1'b1;
    rxen = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst.rxd", int'(rxd), 0);
    check("rst.valid", int'(rxvalid), 0);
    check("rst.sof", int'(rxsof), 0);
    check("rst.eof", int'(rxeof), 0);
    check("rst.ferr", int'(rxferr), 0);
    check("rst.abort", int'(rxabort), 0);
    check("rst.flag", int'(rxflag), 0);
    check("rst.fcs", int'(rxfcserr), 0);
    rst = 1'b0;

    // Ones while hunting: no abort, no flag.
    snap();
    repeat (20) send_bit(1'b1);
    settle();
    check_frame("hunt_ones", 0, 32'h0, 0, 0, 0, 0);

    // Basic four-octet frame.
    snap();
    send_flag();
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
    send_flag();
    settle();
    check_frame("basic", 4, 32'hF00F55AA, 1, 0, 0, 2);

    // Zero-stuffed payload including an in-band 0x7E.
    snap();
    send_flag();
    send_byte(8'hFF); send_byte(8'h7E); send_byte(8'h3F); send_byte(8'h01);
    send_flag();
    settle();
    check_frame("stuffed", 4, 32'h013F7EFF, 1, 0, 0, 2);

    // One octet then an abort.
    snap();
    send_flag();
    send_byte(8'h12);
    send_raw(8'hFF, 7);
    settle();
    check_frame("abort", 1, 32'h00000012, 0, 0, 1, 1);

    // Recovery after abort.
    snap();
    send_flag();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_flag();
    settle();
    check_frame("recover", 4, 32'h04030201, 1, 0, 0, 2);

    // Short and misaligned frame.
    snap();
    send_flag();
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    send_raw(8'h05, 3);
    send_flag();
    settle();
    check_frame("short", 3, 32'h00C3B2A1, 1, 1, 0, 2);

    // Enough octets but residual bit left over.
    snap();
    send_flag();
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_raw(8'h00, 1);
    send_flag();
    settle();
    check_frame("misalign", 4, 32'h44332211, 1, 1, 0, 2);

    // Idle fill flags: no end of frame.
    snap();
    send_flag(); send_flag(); send_flag();
    settle();
    check_frame("idle", 0, 32'h0, 0, 0, 0, 3);

    // Abort outside a frame returns to hunt silently; data is then ignored.
    snap();
    send_raw(8'hFF, 8);
    send_byte(8'h55); send_byte(8'h55); send_byte(8'h0F);
    settle();
    check_frame("hunt_abort", 0, 32'h0, 0, 0, 0, 0);

    // Sparse bit strobes, one in three cycles.
    gap = 2;
    snap();
    send_flag();
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'h0F); send_byte(8'hF0);
    send_flag();
    settle();
    check_frame("slow", 4, 32'hF00F55AA, 1, 0, 0, 2);
    gap = 0;

`ifdef RX_FCS_CHECK_EN
    snap();
    send_flag();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h2F); send_byte(8'h25);
    send_flag();
    settle();
    check("fcs_good.eof", m_eof - b_eof, 1);
    check("fcs_good.err", m_fcs - b_fcs, 0);

    snap();
    send_flag();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h2F); send_byte(8'h24);
    send_flag();
    settle();
    check("fcs_bad.eof", m_eof - b_eof, 1);
    check("fcs_bad.err", m_fcs - b_fcs, 1);

    gap = 2;
    snap();
    send_flag();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h2F); send_byte(8'h25);
    send_flag();
    settle();
    check("fcs_slow.eof", m_eof - b_eof, 1);
    check("fcs_slow.err", m_fcs - b_fcs, 0);
    gap = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
